// File: rtl/door_map_animator.sv
// Room-map wall renderer for the 96x64 OLED with four animated sliding doors.
// Each door leaf has its own open/close FSM; the pixel for (x,y) is registered.

module door_leaf #(
   parameter int ANIM_STEPS = 8,
   parameter int PW         = $clog2(ANIM_STEPS) + 1
) (
   input  logic          basys_clk,
   input  logic          rst_n,
   input  logic          i_tick,
   input  logic          i_req,
   output logic [PW-1:0] o_pos,
   output logic          o_open,
   output logic          o_busy
);

   typedef enum logic [1:0] {S_CLOSED, S_OPENING, S_OPEN, S_CLOSING} state_t;

   localparam logic [PW-1:0] P_FULL = PW'(ANIM_STEPS);
   localparam logic [PW-1:0] P_LAST = PW'(ANIM_STEPS - 1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   state_t        r_state;
   logic [PW-1:0] r_pos;
   logic          r_open;
   logic          r_busy;

   // Saturating ends: a reversal straight after OPEN/CLOSED can leave OPENING at
   // full or CLOSING at zero, so the step clamps instead of running past the range.
   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CLOSED;
         r_pos   <= '0;
         r_open  <= 1'b0;
         r_busy  <= 1'b0;
      end else if (i_tick) begin
         case (r_state)
            S_CLOSED: begin
               if (i_req) begin
                  r_state <= S_OPENING;
                  r_busy  <= 1'b1;
               end
            end
            S_OPENING: begin
               if (!i_req) begin
                  r_state <= S_CLOSING;
               end else if (r_pos >= P_LAST) begin
                  r_pos   <= P_FULL;
                  r_state <= S_OPEN;
                  r_open  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_pos <= r_pos + P_ONE;
               end
            end
            S_OPEN: begin
               if (!i_req) begin
                  r_state <= S_CLOSING;
                  r_open  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_CLOSING: begin
               if (i_req) begin
                  r_state <= S_OPENING;
               end else if (r_pos <= P_ONE) begin
                  r_pos   <= '0;
                  r_state <= S_CLOSED;
                  r_busy  <= 1'b0;
               end else begin
                  r_pos <= r_pos - P_ONE;
               end
            end
            default: begin
               r_state <= S_CLOSED;
               r_pos   <= '0;
               r_open  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_pos  = r_pos;
   assign o_open = r_open;
   assign o_busy = r_busy;

endmodule

module door_map_animator #(
   parameter int          H_TOP       = 30,
   parameter int          H_BOT       = 34,
   parameter int          V_LEFT      = 46,
   parameter int          V_RIGHT     = 50,
   parameter int          L_GAP_L     = 10,
   parameter int          L_GAP_R     = 17,
   parameter int          R_GAP_L     = 78,
   parameter int          R_GAP_R     = 85,
   parameter int          T_GAP_T     = 8,
   parameter int          T_GAP_B     = 15,
   parameter int          B_GAP_T     = 48,
   parameter int          B_GAP_B     = 55,
   parameter int          ANIM_STEPS  = 8,
   parameter logic [15:0] WALL_COLOUR = 16'hFFE0,
   parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
   input  logic        basys_clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic [6:0]  x,
   input  logic [6:0]  y,
   input  logic [3:0]  door_req,
   output logic [15:0] oled_data,
   output logic [3:0]  door_open,
   output logic [3:0]  door_busy
);

   localparam int PW   = $clog2(ANIM_STEPS) + 1;
   localparam int LOG2 = $clog2(ANIM_STEPS);

   localparam logic [7:0] HT  = 8'(H_TOP);
   localparam logic [7:0] HB  = 8'(H_BOT);
   localparam logic [7:0] VL  = 8'(V_LEFT);
   localparam logic [7:0] VR  = 8'(V_RIGHT);
   localparam logic [7:0] LGL = 8'(L_GAP_L);
   localparam logic [7:0] LGR = 8'(L_GAP_R);
   localparam logic [7:0] RGL = 8'(R_GAP_L);
   localparam logic [7:0] RGR = 8'(R_GAP_R);
   localparam logic [7:0] TGT = 8'(T_GAP_T);
   localparam logic [7:0] TGB = 8'(T_GAP_B);
   localparam logic [7:0] BGT = 8'(B_GAP_T);
   localparam logic [7:0] BGB = 8'(B_GAP_B);

   logic [7:0]           w_x;
   logic [7:0]           w_y;
   logic [3:0][PW-1:0]   w_pos;
   logic [3:0]           w_in_door;
   logic [3:0]           w_door_bg;
   logic                 w_wall_h;
   logic                 w_wall_v;
   logic [15:0]          w_pix;
   logic [15:0]          r_pix;

   assign w_x = {1'b0, x};
   assign w_y = {1'b0, y};

   // Doors 0/1 slide along x inside the horizontal band, doors 2/3 along y inside the vertical band.
   for (genvar gi = 0; gi < 4; gi++) begin : g_door
      localparam bit IS_H = (gi < 2);
      localparam int GF   = (gi == 0) ? L_GAP_L : (gi == 1) ? R_GAP_L : (gi == 2) ? T_GAP_T : B_GAP_T;
      localparam int GL   = (gi == 0) ? L_GAP_R : (gi == 1) ? R_GAP_R : (gi == 2) ? T_GAP_B : B_GAP_B;
      localparam logic [7:0]  F8 = 8'(GF);
      localparam logic [7:0]  L8 = 8'(GL);
      localparam logic [15:0] LG = 16'(GL - GF + 1);

      logic [7:0]  w_c;
      logic        w_band;
      logic [7:0]  w_off;
      logic [15:0] w_len;

      assign w_c            = IS_H ? w_x : w_y;
      assign w_band         = IS_H ? ((w_y > HT) && (w_y < HB)) : ((w_x > VL) && (w_x < VR));
      assign w_in_door[gi]  = w_band && (w_c >= F8) && (w_c <= L8);
      assign w_off          = w_c - F8;
      assign w_len          = (16'(w_pos[gi]) * LG) >> LOG2;
      assign w_door_bg[gi]  = ({8'd0, w_off} < w_len);

      door_leaf #(.ANIM_STEPS(ANIM_STEPS), .PW(PW)) u_leaf (
         .basys_clk (basys_clk),
         .rst_n     (rst_n),
         .i_tick    (frame_tick),
         .i_req     (door_req[gi]),
         .o_pos     (w_pos[gi]),
         .o_open    (door_open[gi]),
         .o_busy    (door_busy[gi])
      );
   end

   always_comb begin
      w_wall_h = (w_y > HT) && (w_y < HB) &&
                 ((w_x <= LGL) || ((w_x >= LGR) && (w_x <= RGL)) || (w_x >= RGR));
      w_wall_v = (w_x > VL) && (w_x < VR) &&
                 ((w_y <= TGT) || ((w_y >= TGB) && (w_y <= BGT)) || (w_y >= BGB));
      w_pix    = (w_wall_h || w_wall_v) ? WALL_COLOUR : BG_COLOUR;
      // Walk from the highest index down so the lowest-index door has the last word.
      for (int i = 3; i >= 0; i--) begin
         if (w_in_door[i]) w_pix = w_door_bg[i] ? BG_COLOUR : WALL_COLOUR;
      end
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) r_pix <= BG_COLOUR;
      else        r_pix <= w_pix;
   end

   assign oled_data = r_pix;

endmodule
